pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/batpu_ctrl_pkg.sv | 12 +
 rtl/reg_scoreboard.sv | 59 +++++
 rtl/pipeline_ctrl.sv | 83 ++++++++
 tb/tb_pipeline_ctrl.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/batpu_ctrl_pkg.sv
// batpu_ctrl_pkg: shared types and sizing for the pipeline controller and its scoreboard.
package batpu_ctrl_pkg;
    localparam int NUM_REGS = 16;
    localparam int SB_MAX   = 3;
    localparam int CNT_W    = 2;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        HALTED = 2'd2
    } state_e;
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register in-flight write counters with hazard detection.
module reg_scoreboard
    import batpu_ctrl_pkg::*;
#(
    parameter int  NUM_REGS = batpu_ctrl_pkg::NUM_REGS,
    parameter int  SB_MAX   = batpu_ctrl_pkg::SB_MAX,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid_i,
    input  logic          rs1_used_i,
    input  logic          rs2_used_i,
    input  logic          rd_we_i,
    input  logic [AW-1:0] rs1_i,
    input  logic [AW-1:0] rs2_i,
    input  logic [AW-1:0] rd_i,
    input  logic          inc_i,
    input  logic          dec_i,
    input  logic [AW-1:0] wb_addr_i,
    input  logic          clr_i,
    output logic          hazard_o,
    output logic          err_o
);
    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic [NUM_REGS-1:0] up, dn, zero;
    logic                err_q, err_d;

    assign up = inc_i ? NUM_REGS'(1) << rd_i : '0;
    assign dn = dec_i ? NUM_REGS'(1) << wb_addr_i : '0;

    assign hazard_o = valid_i && ((rs1_used_i && rs1_i != '0 && cnt_q[rs1_i] != '0) ||
                                  (rs2_used_i && rs2_i != '0 && cnt_q[rs2_i] != '0) ||
                                  (rd_we_i && rd_i != '0 && cnt_q[rd_i] == CNT_W'(SB_MAX)));

    // r0 is pinned at zero; a simultaneous inc/dec on one register cancels out
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            zero[i]  = i != 0 && cnt_q[i] == '0;
            cnt_d[i] = (i == 0 || clr_i) ? '0 :
                       (up[i] && !dn[i]) ? cnt_q[i] + 1'b1 :
                       (dn[i] && !up[i] && !zero[i]) ? cnt_q[i] - 1'b1 : cnt_q[i];
        end
    end

    assign err_d = err_q || |(dn & ~up & zero);
    assign err_o = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '{default: '0};
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: issue/stall/bubble decisions, RUN/STALL/HALTED FSM and stall statistics.
module pipeline_ctrl
    import batpu_ctrl_pkg::*;
#(
    parameter int  NUM_REGS = batpu_ctrl_pkg::NUM_REGS,
    parameter int  SB_MAX   = batpu_ctrl_pkg::SB_MAX,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          async_rst_n,
    input  logic          clk_en,
    input  logic          start,
    input  logic          dec_valid,
    input  logic [AW-1:0] dec_rs1,
    input  logic [AW-1:0] dec_rs2,
    input  logic          dec_rs1_used,
    input  logic          dec_rs2_used,
    input  logic [AW-1:0] dec_rd,
    input  logic          dec_rd_we,
    input  logic          flush,
    input  logic [AW-1:0] wb_rd_addr,
    input  logic          wb_reg_we,
    input  logic          wb_clk_hlt,
    output logic          pipe_en,
    output logic          stall,
    output logic          issue,
    output logic          bubble,
    output logic          halted,
    output logic [1:0]    state,
    output logic [7:0]    stall_cnt,
    output logic          sb_err
);
    state_e     state_q, state_d;
    logic [7:0] stall_cnt_q, stall_cnt_d;
    logic       hazard, halt_go;

    assign pipe_en   = clk_en && state_q != HALTED;
    assign issue     = async_rst_n && pipe_en && dec_valid && !hazard && !flush;
    assign stall     = pipe_en && hazard && !flush;
    assign bubble    = pipe_en && !issue;
    assign halted    = state_q == HALTED;
    assign state     = state_q;
    assign stall_cnt = stall_cnt_q;
    assign halt_go   = pipe_en && wb_clk_hlt;

    reg_scoreboard #(.NUM_REGS(NUM_REGS), .SB_MAX(SB_MAX)) u_sb (
        .clk       (clk),
        .rst_n     (async_rst_n),
        .valid_i   (dec_valid),
        .rs1_used_i(dec_rs1_used),
        .rs2_used_i(dec_rs2_used),
        .rd_we_i   (dec_rd_we),
        .rs1_i     (dec_rs1),
        .rs2_i     (dec_rs2),
        .rd_i      (dec_rd),
        .inc_i     (issue && dec_rd_we),
        .dec_i     (pipe_en && wb_reg_we),
        .wb_addr_i (wb_rd_addr),
        .clr_i     (halt_go),
        .hazard_o  (hazard),
        .err_o     (sb_err)
    );

    // halt at writeback wins over a pending stall
    always_comb begin
        state_d = state_q;
        if (clk_en)
            state_d = (state_q == HALTED) ? (start ? RUN : HALTED) :
                      halt_go ? HALTED : stall ? STALL : RUN;
    end

    assign stall_cnt_d = (stall && stall_cnt_q != 8'hFF) ? stall_cnt_q + 8'd1 : stall_cnt_q;

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed and randomized checks of pipeline_ctrl against a behavioural model.
module tb_pipeline_ctrl;
    logic       clk = 1'b0;
    logic       async_rst_n, clk_en, start, dec_valid, dec_rs1_used, dec_rs2_used, dec_rd_we;
    logic       flush, wb_reg_we, wb_clk_hlt;
    logic [3:0] dec_rs1, dec_rs2, dec_rd, wb_rd_addr;
    logic       pipe_en, stall, issue, bubble, halted, sb_err;
    logic [1:0] state;
    logic [7:0] stall_cnt;
    logic [15:0] actv;

    int total = 0;
    int bad = 0;
    int cnt[16];
    int mst, msc;
    bit merr;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk(clk), .async_rst_n(async_rst_n), .clk_en(clk_en), .start(start),
        .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
        .dec_rd(dec_rd), .dec_rd_we(dec_rd_we), .flush(flush),
        .wb_rd_addr(wb_rd_addr), .wb_reg_we(wb_reg_we), .wb_clk_hlt(wb_clk_hlt),
        .pipe_en(pipe_en), .stall(stall), .issue(issue), .bubble(bubble),
        .halted(halted), .state(state), .stall_cnt(stall_cnt), .sb_err(sb_err)
    );

    assign actv = {pipe_en, stall, issue, bubble, halted, state, stall_cnt, sb_err};

    function automatic bit m_hz();
        return dec_valid && ((dec_rs1_used && dec_rs1 != 0 && cnt[dec_rs1] != 0) ||
                             (dec_rs2_used && dec_rs2 != 0 && cnt[dec_rs2] != 0) ||
                             (dec_rd_we && dec_rd != 0 && cnt[dec_rd] == 3));
    endfunction
    function automatic bit m_pe();
        return clk_en && mst != 2;
    endfunction
    function automatic bit m_iss();
        return async_rst_n && m_pe() && dec_valid && !m_hz() && !flush;
    endfunction
    function automatic bit m_stl();
        return m_pe() && m_hz() && !flush;
    endfunction
    function automatic logic [15:0] expv();
        return {m_pe(), m_stl(), m_iss(), m_pe() && !m_iss(), mst == 2, 2'(mst), 8'(msc), merr};
    endfunction

    task automatic model_reset();
        foreach (cnt[i]) cnt[i] = 0;
        mst = 0;
        msc = 0;
        merr = 0;
    endtask

    // advance one clock; the model computes its next state from pre-edge inputs
    task automatic tick();
        int ui, di, nst, nsc;
        int nc[16];
        bit nerr;
        nc = cnt; nst = mst; nsc = msc; nerr = merr;
        ui = (m_iss() && dec_rd_we && dec_rd != 0) ? int'(dec_rd) : -1;
        di = (m_pe() && wb_reg_we && wb_rd_addr != 0) ? int'(wb_rd_addr) : -1;
        if (m_stl() && msc < 255) nsc = msc + 1;
        if (di >= 0 && di != ui) begin
            if (cnt[di] == 0) nerr = 1;
            else nc[di] = nc[di] - 1;
        end
        if (ui >= 0 && ui != di) nc[ui] = nc[ui] + 1;
        if (clk_en) begin
            if (mst == 2) begin
                if (start) nst = 0;
            end else if (wb_clk_hlt) begin
                nst = 2;
                foreach (nc[i]) nc[i] = 0;
            end else nst = m_stl() ? 1 : 0;
        end
        @(posedge clk);
        if (async_rst_n) begin
            cnt = nc; mst = nst; msc = nsc; merr = nerr;
        end
        #1;
    endtask

    task automatic idle();
        clk_en = 1; start = 0; dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0;
        dec_rs1_used = 0; dec_rs2_used = 0; dec_rd = 0; dec_rd_we = 0;
        flush = 0; wb_rd_addr = 0; wb_reg_we = 0; wb_clk_hlt = 0;
    endtask

    task automatic set_dec(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                           input int rd, input bit we);
        dec_valid = v; dec_rs1 = 4'(r1); dec_rs1_used = u1; dec_rs2 = 4'(r2);
        dec_rs2_used = u2; dec_rd = 4'(rd); dec_rd_we = we;
    endtask

    task automatic test_reset();
        async_rst_n = 0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            idle();
            clk_en = 1'($urandom_range(0, 1));
            set_dec(1, $urandom_range(0, 15), 1, $urandom_range(0, 15), 1, $urandom_range(0, 15), 1);
            wb_reg_we = 1;
            wb_rd_addr = 4'($urandom_range(1, 15));
            #1;
            total++;
            if ({pipe_en, stall, issue, halted, state, stall_cnt, sb_err} !== {clk_en, 3'b000, 2'd0, 8'd0, 1'b0}) begin
                bad++;
                $display("FAIL reset_%0d got=%b want pe=%b others 0", i, actv, clk_en);
            end
            @(posedge clk);
            #1;
        end
        idle();
        #1 async_rst_n = 1;
        tick();
    endtask

    task automatic test_raw();
        idle();
        set_dec(1, 0, 0, 0, 0, 3, 1);
        #1;
        total++;
        if (issue !== 1'b1 || actv !== expv()) begin bad++; $display("FAIL raw_issue got=%h want=%h", actv, expv()); end
        tick();
        set_dec(1, 3, 1, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            #1;
            total++;
            if (stall !== 1'b1 || (k > 0 && state !== 2'd1) || actv !== expv()) begin
                bad++; $display("FAIL raw_stall%0d got=%h want=%h", k, actv, expv());
            end
            tick();
        end
        wb_reg_we = 1; wb_rd_addr = 3;
        #1;
        total++;
        if (stall !== 1'b1 || actv !== expv()) begin bad++; $display("FAIL raw_wb got=%h want=%h", actv, expv()); end
        tick();
        wb_reg_we = 0;
        #1;
        total++;
        if (issue !== 1'b1 || stall !== 1'b0 || actv !== expv()) begin bad++; $display("FAIL raw_resume got=%h want=%h", actv, expv()); end
        tick();
        idle();
        #1;
        total++;
        if (state !== 2'd0 || actv !== expv()) begin bad++; $display("FAIL raw_run got=%h want=%h", actv, expv()); end
        tick();
    endtask

    task automatic test_r0();
        idle();
        set_dec(1, 0, 0, 0, 0, 0, 1);
        #1;
        total++;
        if (issue !== 1'b1 || actv !== expv()) begin bad++; $display("FAIL r0_write got=%h want=%h", actv, expv()); end
        tick();
        set_dec(1, 0, 1, 0, 1, 0, 1);
        #1;
        total++;
        if (stall !== 1'b0 || issue !== 1'b1 || actv !== expv()) begin bad++; $display("FAIL r0_read got=%h want=%h", actv, expv()); end
        tick();
    endtask

    task automatic test_sat();
        idle();
        for (int k = 0; k < 3; k++) begin
            set_dec(1, 0, 0, 0, 0, 5, 1);
            #1;
            total++;
            if (issue !== 1'b1 || actv !== expv()) begin bad++; $display("FAIL sat_fill%0d got=%h want=%h", k, actv, expv()); end
            tick();
        end
        #1;
        total++;
        if (stall !== 1'b1 || issue !== 1'b0 || actv !== expv()) begin bad++; $display("FAIL sat_full got=%h want=%h", actv, expv()); end
        tick();
        wb_reg_we = 1; wb_rd_addr = 5;
        #1;
        total++;
        if (stall !== 1'b1 || actv !== expv()) begin bad++; $display("FAIL sat_wb got=%h want=%h", actv, expv()); end
        tick();
        #1;
        total++;
        if (issue !== 1'b1 || actv !== expv()) begin bad++; $display("FAIL sat_both got=%h want=%h", actv, expv()); end
        tick();
        wb_reg_we = 0;
        #1;
        total++;
        if (issue !== 1'b1 || actv !== expv()) begin bad++; $display("FAIL sat_refill got=%h want=%h", actv, expv()); end
        tick();
        #1;
        total++;
        if (stall !== 1'b1 || actv !== expv()) begin bad++; $display("FAIL sat_again got=%h want=%h", actv, expv()); end
        idle();
        wb_reg_we = 1; wb_rd_addr = 5;
        for (int k = 0; k < 3; k++) tick();
        idle();
        set_dec(1, 5, 1, 0, 0, 0, 0);
        #1;
        total++;
        if (stall !== 1'b0 || issue !== 1'b1 || actv !== expv()) begin bad++; $display("FAIL sat_drain got=%h want=%h", actv, expv()); end
        tick();
    endtask

    task automatic test_halt();
        idle();
        set_dec(1, 0, 0, 0, 0, 7, 1);
        tick();
        set_dec(1, 7, 1, 0, 0, 0, 0);
        wb_clk_hlt = 1;
        #1;
        total++;
        if (stall !== 1'b1 || actv !== expv()) begin bad++; $display("FAIL halt_req got=%h want=%h", actv, expv()); end
        tick();
        wb_clk_hlt = 0;
        wb_reg_we = 1; wb_rd_addr = 7;
        for (int k = 0; k < 2; k++) begin
            #1;
            total++;
            if (halted !== 1'b1 || pipe_en !== 1'b0 || issue !== 1'b0 || actv !== expv()) begin
                bad++; $display("FAIL halt_hold%0d got=%h want=%h", k, actv, expv());
            end
            tick();
        end
        wb_reg_we = 0;
        start = 1;
        #1;
        total++;
        if (halted !== 1'b1 || actv !== expv()) begin bad++; $display("FAIL halt_start got=%h want=%h", actv, expv()); end
        tick();
        start = 0;
        #1;
        total++;
        if (state !== 2'd0 || stall !== 1'b0 || issue !== 1'b1 || actv !== expv()) begin
            bad++; $display("FAIL halt_resume got=%h want=%h", actv, expv());
        end
        tick();
    endtask

    task automatic test_flush();
        int sc;
        idle();
        set_dec(1, 0, 0, 0, 0, 9, 1);
        tick();
        set_dec(1, 0, 0, 9, 1, 9, 1);
        flush = 1;
        sc = msc;
        #1;
        total++;
        if (bubble !== 1'b1 || stall !== 1'b0 || issue !== 1'b0 || actv !== expv()) begin
            bad++; $display("FAIL flush_kill got=%h want=%h", actv, expv());
        end
        tick();
        idle();
        #1;
        total++;
        if (stall_cnt !== 8'(sc) || actv !== expv()) begin bad++; $display("FAIL flush_cnt got=%h want=%h", actv, expv()); end
        wb_reg_we = 1; wb_rd_addr = 9;
        tick();
    endtask

    task automatic test_err();
        idle();
        wb_reg_we = 1; wb_rd_addr = 6;
        #1;
        total++;
        if (sb_err !== 1'b0 || actv !== expv()) begin bad++; $display("FAIL err_pre got=%h want=%h", actv, expv()); end
        tick();
        idle();
        for (int k = 0; k < 2; k++) begin
            #1;
            total++;
            if (sb_err !== 1'b1 || actv !== expv()) begin bad++; $display("FAIL err_sticky%0d got=%h want=%h", k, actv, expv()); end
            tick();
        end
    endtask

    task automatic test_freeze();
        int sc;
        idle();
        set_dec(1, 0, 0, 0, 0, 11, 1);
        tick();
        set_dec(1, 11, 1, 0, 0, 0, 0);
        tick();
        clk_en = 0;
        sc = msc;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++;
            if (state !== 2'd1 || stall_cnt !== 8'(sc) || pipe_en !== 1'b0 || actv !== expv()) begin
                bad++; $display("FAIL freeze%0d got=%h want=%h", k, actv, expv());
            end
            tick();
        end
        clk_en = 1;
        #1;
        total++;
        if (stall !== 1'b1 || actv !== expv()) begin bad++; $display("FAIL freeze_exit got=%h want=%h", actv, expv()); end
        tick();
    endtask

    task automatic test_reset_mid();
        #1;
        total++;
        if (state !== 2'd1 || sb_err !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%h want state=1 err=1", actv); end
        #2 async_rst_n = 0;
        model_reset();
        #1;
        total++;
        if (state !== 2'd0 || stall_cnt !== 8'd0 || sb_err !== 1'b0 || stall !== 1'b0 || issue !== 1'b0) begin
            bad++; $display("FAIL rstmid_now got=%h want state/cnt/err/stall/issue 0", actv);
        end
        tick();
        async_rst_n = 1;
        #1;
        total++;
        if (issue !== 1'b1 || stall !== 1'b0 || actv !== expv()) begin bad++; $display("FAIL rstmid_after got=%h want=%h", actv, expv()); end
        tick();
    endtask

    task automatic test_random();
        int r;
        for (int k = 0; k < 400; k++) begin
            clk_en = $urandom_range(0, 9) != 0;
            start = $urandom_range(0, 3) == 0;
            set_dec($urandom_range(0, 3) != 0, $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
            flush = $urandom_range(0, 7) == 0;
            wb_reg_we = $urandom_range(0, 2) == 0;
            wb_clk_hlt = $urandom_range(0, 39) == 0;
            r = $urandom_range(0, 15);
            for (int t = 0; t < 8 && $urandom_range(0, 7) != 0 && cnt[r] == 0; t++) r = $urandom_range(1, 7);
            wb_rd_addr = 4'(r);
            #1;
            total++;
            if (actv !== expv()) begin bad++; $display("FAIL rand%0d got=%h want=%h", k, actv, expv()); end
            tick();
        end
    endtask

    task automatic test_stall_sat();
        idle();
        #1 async_rst_n = 0;
        model_reset();
        tick();
        async_rst_n = 1;
        set_dec(1, 0, 0, 0, 0, 2, 1);
        tick();
        set_dec(1, 2, 1, 0, 0, 0, 0);
        for (int k = 0; k < 260; k++) begin
            #1;
            total++;
            if (actv !== expv()) begin bad++; $display("FAIL ssat%0d got=%h want=%h", k, actv, expv()); end
            tick();
        end
        #1;
        total++;
        if (stall_cnt !== 8'd255 || stall !== 1'b1) begin bad++; $display("FAIL ssat_end got=%0d want=255", stall_cnt); end
    endtask

    initial begin
        idle();
        async_rst_n = 0;
        model_reset();
        test_reset();
        test_raw();
        test_r0();
        test_sat();
        test_halt();
        test_flush();
        test_err();
        test_freeze();
        test_reset_mid();
        test_random();
        test_stall_sat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
